// File: rtl/reg_file_multi.sv
// Parametrised 2-read/1-write register file with registered reads, optional zero
// register, optional write-to-read bypass and a post-reset clear sweep.
module reg_file_multi #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    input  logic [ADDR_W-1:0] write_reg_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              regWrite,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              init_busy_r;
    logic [DATA_W-1:0] read_data_1_r;
    logic [DATA_W-1:0] read_data_2_r;
    logic [DATA_W-1:0] bank_r [DEPTH];

    logic              bank_we_s;
    logic [ADDR_W-1:0] bank_waddr_s;
    logic [DATA_W-1:0] bank_wdata_s;
    logic              zero_wr_s;
    logic [DATA_W-1:0] rd1_next_s;
    logic [DATA_W-1:0] rd2_next_s;

    // Read mux for one port: zero register first, then forwarding, then the stored value.
    function automatic logic [DATA_W-1:0] read_select(
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] stored,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] result;
        if (ZERO_REG && (raddr == ZERO_ADDR)) begin
            result = ZERO_DATA;
        end else if (BYPASS && wen && (waddr == raddr)) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Bank write port: the clear sweep owns it in INIT, the user owns it in READY.
    always_comb begin
        bank_we_s    = 1'b0;
        bank_waddr_s = clr_cnt_r;
        bank_wdata_s = ZERO_DATA;
        zero_wr_s    = ZERO_REG && (write_reg_addr == ZERO_ADDR);
        if (rst) begin
            bank_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    bank_we_s    = 1'b1;
                    bank_waddr_s = clr_cnt_r;
                    bank_wdata_s = ZERO_DATA;
                end
                ST_READY: begin
                    bank_we_s    = regWrite && !zero_wr_s;
                    bank_waddr_s = write_reg_addr;
                    bank_wdata_s = write_data;
                end
                default: begin
                    bank_we_s = 1'b0;
                end
            endcase
        end
    end

    // Next read values; the bank is sampled before this edge's write lands.
    always_comb begin
        rd1_next_s = read_select(read_reg_1, bank_r[read_reg_1], regWrite,
                                 write_reg_addr, write_data);
        rd2_next_s = read_select(read_reg_2, bank_r[read_reg_2], regWrite,
                                 write_reg_addr, write_data);
    end

    // Storage array; intentionally not reset, the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (bank_we_s) begin
            bank_r[bank_waddr_s] <= bank_wdata_s;
        end
    end

    // Control state, clear counter and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            clr_cnt_r     <= ZERO_ADDR;
            init_busy_r   <= 1'b1;
            read_data_1_r <= ZERO_DATA;
            read_data_2_r <= ZERO_DATA;
        end else begin
            case (state_r)
                ST_INIT: begin
                    clr_cnt_r     <= clr_cnt_r + ONE_ADDR;
                    read_data_1_r <= ZERO_DATA;
                    read_data_2_r <= ZERO_DATA;
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r     <= ST_READY;
                        init_busy_r <= 1'b0;
                    end else begin
                        state_r     <= ST_INIT;
                        init_busy_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    read_data_1_r <= rd1_next_s;
                    read_data_2_r <= rd2_next_s;
                end
                default: begin
                    state_r       <= ST_INIT;
                    clr_cnt_r     <= ZERO_ADDR;
                    init_busy_r   <= 1'b1;
                    read_data_1_r <= ZERO_DATA;
                    read_data_2_r <= ZERO_DATA;
                end
            endcase
        end
    end

    assign read_data_1 = read_data_1_r;
    assign read_data_2 = read_data_2_r;
    assign init_busy   = init_busy_r;

endmodule

// File: tb/tb_reg_file_multi.sv
// Directed bench for reg_file_multi: default, no-zero/no-bypass, no-zero/bypass
// and a narrow 16x8 configuration, all checked against hand-computed values.
module tb_reg_file_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [4:0] rd1 = 5'd0, rd2 = 5'd0, wa = 5'd0;
    logic [7:0] wd = 8'd0;
    logic       we = 1'b0;

    logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2, d_rd1, d_rd2;
    logic       a_busy, b_busy, d_busy;

    logic [2:0]  c_rr1 = 3'd0, c_rr2 = 3'd0, c_wa = 3'd0;
    logic [15:0] c_wd = 16'd0;
    logic        c_we = 1'b0;
    logic [15:0] c_rd1, c_rd2;
    logic        c_busy;

    int checks = 0;
    int errors = 0;
    int na, nc;

    always #5 clk = ~clk;

    reg_file_multi dut_a (
        .clk(clk), .rst(rst), .read_reg_1(rd1), .read_reg_2(rd2),
        .write_reg_addr(wa), .write_data(wd), .regWrite(we),
        .read_data_1(a_rd1), .read_data_2(a_rd2), .init_busy(a_busy)
    );

    reg_file_multi #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .read_reg_1(rd1), .read_reg_2(rd2),
        .write_reg_addr(wa), .write_data(wd), .regWrite(we),
        .read_data_1(b_rd1), .read_data_2(b_rd2), .init_busy(b_busy)
    );

    reg_file_multi #(.ZERO_REG(1'b0), .BYPASS(1'b1)) dut_d (
        .clk(clk), .rst(rst), .read_reg_1(rd1), .read_reg_2(rd2),
        .write_reg_addr(wa), .write_data(wd), .regWrite(we),
        .read_data_1(d_rd1), .read_data_2(d_rd2), .init_busy(d_busy)
    );

    reg_file_multi #(.DATA_W(16), .ADDR_W(3)) dut_c (
        .clk(clk), .rst(rst), .read_reg_1(c_rr1), .read_reg_2(c_rr2),
        .write_reg_addr(c_wa), .write_data(c_wd), .regWrite(c_we),
        .read_data_1(c_rd1), .read_data_2(c_rd2), .init_busy(c_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps until dut_a leaves INIT (bounded); also records when dut_c left INIT.
    task automatic count_busy(output int n_a, output int n_c);
        n_a = 0;
        n_c = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (n_c == 0 && c_busy == 1'b0) n_c = k;
            if (a_busy == 1'b0) begin
                n_a = k;
                break;
            end
        end
    endtask

    initial begin
        // Reset held for two edges
        rst = 1'b1;
        step();
        step();
        chk("rst_busy_a", {15'd0, a_busy}, 16'd1);
        chk("rst_busy_c", {15'd0, c_busy}, 16'd1);
        chk("rst_rd1_a", {8'd0, a_rd1}, 16'h0000);
        chk("rst_rd2_b", {8'd0, b_rd2}, 16'h0000);

        // First INIT edge carries a write to 5 that must be ignored
        rst = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 8'h33; rd1 = 5'd5; rd2 = 5'd5;
        step();
        chk("init_rd1_held", {8'd0, a_rd1}, 16'h0000);
        chk("init_rd2_held", {8'd0, d_rd2}, 16'h0000);
        we = 1'b0;
        count_busy(na, nc);
        chk("init_busy_len", 16'(na + 1), 16'd32);
        chk("init_busy_len_c", 16'(nc + 1), 16'd8);
        chk("ready_busy_b", {15'd0, b_busy}, 16'd0);
        chk("ready_busy_d", {15'd0, d_busy}, 16'd0);

        // Swept entries read zero, including the ignored INIT write target
        rd1 = 5'd1; rd2 = 5'd7;
        step();
        chk("sweep_r1", {8'd0, a_rd1}, 16'h0000);
        chk("sweep_r7", {8'd0, a_rd2}, 16'h0000);
        rd1 = 5'd31; rd2 = 5'd5;
        step();
        chk("sweep_r31", {8'd0, b_rd1}, 16'h0000);
        chk("sweep_r5", {8'd0, a_rd2}, 16'h0000);

        // Basic write then read
        we = 1'b1; wa = 5'd3; wd = 8'h0A; rd1 = 5'd0; rd2 = 5'd0;
        step();
        we = 1'b0; rd1 = 5'd3; rd2 = 5'd6;
        step();
        chk("wr3_rd1_a", {8'd0, a_rd1}, 16'h000A);
        chk("wr3_rd2_a", {8'd0, a_rd2}, 16'h0000);
        chk("wr3_rd1_b", {8'd0, b_rd1}, 16'h000A);

        // Same-cycle write/read of 7 on both ports
        we = 1'b1; wa = 5'd7; wd = 8'h1E; rd1 = 5'd7; rd2 = 5'd7;
        step();
        chk("byp_rd1_a", {8'd0, a_rd1}, 16'h001E);
        chk("byp_rd2_a", {8'd0, a_rd2}, 16'h001E);
        chk("nobyp_rd1_b", {8'd0, b_rd1}, 16'h0000);
        chk("nobyp_rd2_b", {8'd0, b_rd2}, 16'h0000);
        we = 1'b0;
        step();
        chk("nobyp_next_b", {8'd0, b_rd1}, 16'h001E);
        chk("byp_next_a", {8'd0, a_rd2}, 16'h001E);

        // Zero register, with a same-cycle bypass attempt
        we = 1'b1; wa = 5'd0; wd = 8'hFF; rd1 = 5'd0; rd2 = 5'd0;
        step();
        chk("zero_byp_a", {8'd0, a_rd1}, 16'h0000);
        chk("zero_byp_a2", {8'd0, a_rd2}, 16'h0000);
        chk("nozero_byp_d", {8'd0, d_rd1}, 16'h00FF);
        chk("nozero_nobyp_b", {8'd0, b_rd1}, 16'h0000);
        we = 1'b0;
        step();
        chk("zero_read_a", {8'd0, a_rd1}, 16'h0000);
        chk("nozero_read_b", {8'd0, b_rd2}, 16'h00FF);
        chk("nozero_read_d", {8'd0, d_rd2}, 16'h00FF);

        // Reset mid-sweep: write 20, reset, abort sweep at clr_cnt=10
        we = 1'b1; wa = 5'd20; wd = 8'h55; rd1 = 5'd0;
        step();
        we = 1'b0; rd1 = 5'd20;
        step();
        chk("pre_rst_r20", {8'd0, a_rd1}, 16'h0055);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("mid_sweep_busy", {15'd0, a_busy}, 16'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", {15'd0, a_busy}, 16'd1);
        chk("mid_rst_rd1", {8'd0, a_rd1}, 16'h0000);
        rst = 1'b0;
        count_busy(na, nc);
        chk("restart_busy_len", 16'(na), 16'd32);
        chk("restart_busy_len_c", 16'(nc), 16'd8);
        step();
        chk("post_rst_r20_a", {8'd0, a_rd1}, 16'h0000);
        chk("post_rst_r20_d", {8'd0, d_rd1}, 16'h0000);

        // Narrow configuration: fill entries 1..7, then read pairs (i, 8-i)
        c_we = 1'b1;
        for (int i = 1; i < 8; i++) begin
            c_wa = 3'(i);
            c_wd = 16'hA500 + 16'(i);
            step();
        end
        c_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int j;
            j = (8 - i) % 8;
            c_rr1 = 3'(i);
            c_rr2 = 3'(j);
            step();
            chk("narrow_rd1", c_rd1, (i == 0) ? 16'h0000 : 16'hA500 + 16'(i));
            chk("narrow_rd2", c_rd2, (j == 0) ? 16'h0000 : 16'hA500 + 16'(j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
